// File: rtl/hwpe_stream_package.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_package
// Description : Shared types for HWPE-Stream blocks; holds the control and
//               flag records of the store-side (sink) realigner.
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_stream_package;

  // Field widths sized for the widest supported stream (512 bits); each
  // block uses only the low bits matching its own DATA_WIDTH / CNT_WIDTH.
  localparam int unsigned REALIGN_OFFSET_W = 6;
  localparam int unsigned REALIGN_LEN_W    = 32;

  typedef struct packed {
    logic                        enable;
    logic                        realign;
    logic [REALIGN_OFFSET_W-1:0] offset;
    logic [REALIGN_LEN_W-1:0]    line_length;
  } ctrl_sink_realign_t;

  typedef struct packed {
    logic busy;
    logic line_done;
  } flags_sink_realign_t;

  typedef enum logic [1:0] {
    SR_FIRST = 2'd0,
    SR_MID   = 2'd1,
    SR_FLUSH = 2'd2
  } sink_realign_state_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_intf_stream.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_intf_stream
// Description : HWPE-Stream valid/ready handshake bundle with byte strobes.
// Revision    : 1.0 - initial release
// ============================================================================
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
endinterface
`default_nettype wire

// File: rtl/cluster_clock_gating.sv
`default_nettype none
// ============================================================================
// Module      : cluster_clock_gating
// Description : Glitch-free clock gate (latch on low phase + AND), with a
//               test-mode bypass that forces the clock through.
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latched;

  // Enable is captured while the clock is low so clk_o cannot glitch high.
  always_latch begin
    if (!clk_i) en_latched = en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latched;

endmodule
`default_nettype wire

// File: rtl/hwpe_stream_sink_realign.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_sink_realign
// Description : Turns an aligned stream of full words into a byte-misaligned
//               store stream: data is rotated by the line offset, strobes
//               mark valid bytes, and an extra flush beat carries the tail
//               bytes of the last word. Offset 0 degenerates to passthrough.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_stream_sink_realign
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   clear_i,
  input  ctrl_sink_realign_t     ctrl_i,
  output flags_sink_realign_t    flags_o,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned SW = OW + 3;

  // --------------------------------------------------------------------------
  // Gated clock: the whole block freezes when the engine is disabled
  // --------------------------------------------------------------------------
  logic clk_gated;

  cluster_clock_gating i_clk_gate (
    .clk_i     (clk_i),
    .en_i      (ctrl_i.enable),
    .test_en_i (test_mode_i),
    .clk_o     (clk_gated)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  sink_realign_state_t   state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [OW-1:0]         off_q;
  logic                  bypass_q;
  logic [DATA_WIDTH-1:0] prev_q;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic [OW-1:0]        off_in;
  logic [CNT_WIDTH-1:0] len_raw;
  logic [CNT_WIDTH-1:0] len_in;
  logic                 bypass_in;
  logic [OW-1:0]        off_cur;
  logic [OW-1:0]        off_neg;
  logic [SW-1:0]        sh_lo;
  logic [SW-1:0]        sh_hi;
  logic [NB-1:0]        strb_head;
  logic                 mid_last;
  logic                 in_hs;
  logic                 line_done;
  logic                 unused_bits;

  assign off_in    = ctrl_i.offset[OW-1:0];
  assign len_raw   = ctrl_i.line_length[CNT_WIDTH-1:0];
  // A zero-length request still moves one word.
  assign len_in    = (len_raw == '0) ? CNT_WIDTH'(1) : len_raw;
  assign bypass_in = !ctrl_i.realign || (off_in == '0);

  // The live offset comes straight from ctrl while waiting for a line so the
  // first beat is rotated with zero latency; afterwards the latched copy rules.
  assign off_cur   = (state_q == SR_FIRST) ? off_in : off_q;
  assign off_neg   = -off_cur;

  // 8*o and 8*(NB-o); the latter wraps to 0 for o=0, a case bypass covers.
  assign sh_lo     = {off_cur, 3'b000};
  assign sh_hi     = {off_neg, 3'b000};
  assign strb_head = {NB{1'b1}} << off_cur;

  assign mid_last  = (cnt_q == (len_q - CNT_WIDTH'(1)));
  assign in_hs     = push_i.valid && pop_o.ready && (state_q != SR_FLUSH);

  // Strobes of the input stream carry no information here.
  assign unused_bits = ^{ctrl_i, push_i.strb};

  // --------------------------------------------------------------------------
  // Output datapath and handshake steering
  // --------------------------------------------------------------------------
  always_comb begin
    pop_o.valid  = push_i.valid;
    push_i.ready = pop_o.ready;
    pop_o.data   = push_i.data;
    pop_o.strb   = {NB{1'b1}};
    line_done    = 1'b0;
    case (state_q)
      SR_FIRST: begin
        if (!bypass_in) begin
          pop_o.data = push_i.data << sh_lo;
          pop_o.strb = strb_head;
        end
        line_done = in_hs && bypass_in && (len_in == CNT_WIDTH'(1));
      end
      SR_MID: begin
        if (!bypass_q) begin
          pop_o.data = (push_i.data << sh_lo) | (prev_q >> sh_hi);
        end
        line_done = in_hs && bypass_q && mid_last;
      end
      SR_FLUSH: begin
        pop_o.valid  = 1'b1;
        push_i.ready = 1'b0;
        pop_o.data   = prev_q >> sh_hi;
        pop_o.strb   = ~strb_head;
        line_done    = pop_o.ready;
      end
      default: begin
        line_done = 1'b0;
      end
    endcase
  end

  assign flags_o.busy      = (state_q != SR_FIRST);
  assign flags_o.line_done = line_done;

  // --------------------------------------------------------------------------
  // Line sequencer: FIRST -> MID* -> FLUSH (realigned) or back to FIRST
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_gated or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SR_FIRST;
      cnt_q    <= '0;
      len_q    <= '0;
      off_q    <= '0;
      bypass_q <= 1'b0;
      prev_q   <= '0;
    end else if (clear_i) begin
      state_q  <= SR_FIRST;
      cnt_q    <= '0;
      len_q    <= '0;
      off_q    <= '0;
      bypass_q <= 1'b0;
      prev_q   <= '0;
    end else begin
      case (state_q)
        SR_FIRST: begin
          if (in_hs) begin
            off_q    <= off_in;
            len_q    <= len_in;
            bypass_q <= bypass_in;
            prev_q   <= push_i.data;
            if (len_in == CNT_WIDTH'(1)) begin
              cnt_q   <= '0;
              state_q <= bypass_in ? SR_FIRST : SR_FLUSH;
            end else begin
              cnt_q   <= CNT_WIDTH'(1);
              state_q <= SR_MID;
            end
          end
        end
        SR_MID: begin
          if (in_hs) begin
            prev_q <= push_i.data;
            if (mid_last) begin
              cnt_q   <= '0;
              state_q <= bypass_q ? SR_FIRST : SR_FLUSH;
            end else begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        SR_FLUSH: begin
          if (pop_o.ready) begin
            bypass_q <= 1'b0;
            state_q  <= SR_FIRST;
          end
        end
        default: begin
          state_q <= SR_FIRST;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_sink_realign.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_stream_sink_realign
// Description : Directed self-checking bench for the sink realigner
//               (32-bit stream): passthrough, offsets 1..3, backpressure,
//               soft clear, bypass and clock-gated hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_sink_realign;
  import hwpe_stream_package::*;

  logic                clk;
  logic                rst_n;
  logic                test_mode;
  logic                clear;
  ctrl_sink_realign_t  ctrl;
  flags_sink_realign_t flags;

  int passed;
  int failed;
  int total;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop ();

  hwpe_stream_sink_realign #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .clear_i     (clear),
    .ctrl_i      (ctrl),
    .flags_o     (flags),
    .push_i      (push),
    .pop_o       (pop)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs are checked 1 unit later.
  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    push.valid = v;
    push.data  = d;
    pop.ready  = r;
    #1;
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] s,
                      input logic pr, input logic done);
    chk({tag, ".valid"}, 32'(pop.valid), 32'd1);
    chk({tag, ".data"},  pop.data, d);
    chk({tag, ".strb"},  32'(pop.strb), 32'(s));
    chk({tag, ".pready"}, 32'(push.ready), 32'(pr));
    chk({tag, ".done"},  32'(flags.line_done), 32'(done));
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst_n = 1'b0; clear = 1'b0; test_mode = 1'b0;
    ctrl = '0; ctrl.enable = 1'b1; ctrl.realign = 1'b1;
    push.valid = 1'b0; push.data = '0; push.strb = 4'hF; pop.ready = 1'b1;

    // Reset state
    drive(1'b0, 32'h0, 1'b1);
    chk("rst.busy",  32'(flags.busy), 32'd0);
    chk("rst.done",  32'(flags.line_done), 32'd0);
    chk("rst.valid", 32'(pop.valid), 32'd0);
    drive(1'b1, 32'h12345678, 1'b1);
    chk("rst.valid_follow", 32'(pop.valid), 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;

    // o=0, N=3: passthrough, no extra beat
    ctrl.offset = 6'd0; ctrl.line_length = 32'd3;
    drive(1'b1, 32'hA1A2A3A4, 1'b1); beat("o0.a", 32'hA1A2A3A4, 4'hF, 1'b1, 1'b0);
    drive(1'b1, 32'hB1B2B3B4, 1'b1); beat("o0.b", 32'hB1B2B3B4, 4'hF, 1'b1, 1'b0);
    chk("o0.busy_mid", 32'(flags.busy), 32'd1);
    drive(1'b1, 32'hC1C2C3C4, 1'b1); beat("o0.c", 32'hC1C2C3C4, 4'hF, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    chk("o0.busy_end", 32'(flags.busy), 32'd0);
    chk("o0.no_extra", 32'(pop.valid), 32'd0);

    // o=1, N=2; ctrl changes mid-line must be ignored
    ctrl.offset = 6'd1; ctrl.line_length = 32'd2;
    drive(1'b1, 32'h44332211, 1'b1); beat("o1.a", 32'h33221100, 4'hE, 1'b1, 1'b0);
    drive(1'b1, 32'h88776655, 1'b1);
    ctrl.offset = 6'd3; ctrl.line_length = 32'd5; #1;
    beat("o1.b", 32'h77665544, 4'hF, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1); beat("o1.f", 32'h00000088, 4'h1, 1'b0, 1'b1);
    chk("o1.busy_flush", 32'(flags.busy), 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    chk("o1.busy_end", 32'(flags.busy), 32'd0);

    // o=3, line_length=0 treated as one word
    ctrl.offset = 6'd3; ctrl.line_length = 32'd0;
    drive(1'b1, 32'hDDCCBBAA, 1'b1); beat("o3.a", 32'hAA000000, 4'h8, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1); beat("o3.f", 32'h00DDCCBB, 4'h7, 1'b0, 1'b1);

    // o=2, N=2, three stalled cycles in FLUSH with input offered
    ctrl.offset = 6'd2; ctrl.line_length = 32'd2;
    drive(1'b1, 32'h04030201, 1'b1); beat("bp.a", 32'h02010000, 4'hC, 1'b1, 1'b0);
    drive(1'b1, 32'h08070605, 1'b1); beat("bp.b", 32'h06050403, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEADBEEF, 1'b0);
      beat("bp.stall", 32'h00000807, 4'h3, 1'b0, 1'b0);
    end
    drive(1'b1, 32'hDEADBEEF, 1'b1); beat("bp.f", 32'h00000807, 4'h3, 1'b0, 1'b1);
    ctrl.line_length = 32'd1;
    drive(1'b1, 32'hDEADBEEF, 1'b1); beat("bp.next", 32'hBEEF0000, 4'hC, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1); beat("bp.nextf", 32'h0000DEAD, 4'h3, 1'b0, 1'b1);

    // Soft clear in the middle of an o=1 line
    ctrl.offset = 6'd1; ctrl.line_length = 32'd3;
    drive(1'b1, 32'h44332211, 1'b1); beat("clr.a", 32'h33221100, 4'hE, 1'b1, 1'b0);
    drive(1'b1, 32'h88776655, 1'b1);
    clear = 1'b1;
    beat("clr.b", 32'h77665544, 4'hF, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    clear = 1'b0;
    chk("clr.busy", 32'(flags.busy), 32'd0);
    chk("clr.no_flush", 32'(pop.valid), 32'd0);
    ctrl.line_length = 32'd1;
    drive(1'b1, 32'h44332211, 1'b1); beat("clr.next", 32'h33221100, 4'hE, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1); beat("clr.nextf", 32'h00000044, 4'h1, 1'b0, 1'b1);

    // realign=0 with offset=2: passthrough
    ctrl.realign = 1'b0; ctrl.offset = 6'd2; ctrl.line_length = 32'd2;
    drive(1'b1, 32'h12345678, 1'b1); beat("byp.a", 32'h12345678, 4'hF, 1'b1, 1'b0);
    drive(1'b1, 32'h9ABCDEF0, 1'b1); beat("byp.b", 32'h9ABCDEF0, 4'hF, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    chk("byp.busy_end", 32'(flags.busy), 32'd0);

    // enable=0 freezes FLUSH across gated cycles
    ctrl.realign = 1'b1; ctrl.offset = 6'd1; ctrl.line_length = 32'd1;
    drive(1'b1, 32'h44332211, 1'b1); beat("cg.a", 32'h33221100, 4'hE, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    ctrl.enable = 1'b0;
    beat("cg.f0", 32'h00000044, 4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      beat("cg.hold", 32'h00000044, 4'h1, 1'b0, 1'b1);
      chk("cg.busy_hold", 32'(flags.busy), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1);
    ctrl.enable = 1'b1;
    beat("cg.release", 32'h00000044, 4'h1, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    chk("cg.busy_end", 32'(flags.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hwpe_stream_sink_realign.md
# hwpe_stream_sink_realign

Store-side counterpart of the streamer's load realigner. It takes an aligned HWPE-Stream of full words and produces a byte-misaligned stream for memory writes, with rotated data and `strb` set per beat. It sits between the sink datapath and the TCDM store port. Each line of N input words with byte offset o≠0 becomes N+1 output beats: a partial first beat, full middle beats, and a partial flush beat.

## Interface
Parameters:
- `DATA_WIDTH`, 32: stream width in bits; NB = DATA_WIDTH/8 bytes, power of two ≥ 2.
- `CNT_WIDTH`, 16: width of the line-length counter.

Ports:
- `clk_i`  in  1: clock; one clock domain.
- `rst_ni`  in  1: asynchronous reset, active-low.
- `test_mode_i`  in  1: clock-gate bypass.
- `clear_i`  in  1: synchronous soft clear; same effect as reset.
- `ctrl_i`  in  `ctrl_sink_realign_t`: fields `enable`, `realign`, `offset[$clog2(NB)-1:0]` and `line_length[CNT_WIDTH-1:0]` (input words per line).
- `flags_o`  out  `flags_sink_realign_t`: fields `busy` (line in progress or flush pending) and `line_done` (1-cycle pulse on the final beat handshake of a line).
- `push_i`  `hwpe_stream_intf_stream.sink`  DATA_WIDTH: aligned input; its `strb` is ignored.
- `pop_o`  `hwpe_stream_intf_stream.source`  DATA_WIDTH: realigned output with `strb`.

## Operation
- Clock gating: all registers run on the `cluster_clock_gating` output, enabled by `ctrl_i.enable`. When `enable`=0, state is frozen.
- Bypass (`realign`=0, or latched offset o=0):
  - `pop_o.data`=`push_i.data`, `pop_o.strb`='1.
  - `pop_o.valid`=`push_i.valid`, `push_i.ready`=`pop_o.ready`.
  - The word counter still runs so that `line_done` is produced.
- State machine:
  - FIRST (reset state): o_q ← `ctrl_i.offset` on the first handshake. Output data = `push_i.data << 8o` (prev treated as 0). strb = `'1 << o`. Go to MID if N>1, else go to FLUSH.
  - MID: output data = `(push_i.data << 8o) | (prev_q >> 8(NB−o))`, strb='1. On the handshake where cnt == N−1, go to FLUSH.
  - FLUSH: `push_i.ready`=0, `pop_o.valid`=1. Output data = `prev_q >> 8(NB−o)`, strb = `~('1 << o)`. On `pop_o.ready`, pulse `line_done` and go to FIRST.
- prev_q ← `push_i.data` on every input handshake.
- cnt increments on every input handshake and resets to 0 when leaving for FLUSH (or at line end in bypass).
- `line_length`=0 is treated as 1.
- Shift amounts are computed in `$clog2(NB)+3` bits. With o=0 the shift-by-DATA_WIDTH term is never evaluated; bypass applies instead.
- `ctrl_i.offset` and `line_length` are sampled only in FIRST. Changes mid-line are ignored until the next line.

## Timing
- Zero latency: in FIRST and MID, pop data, valid and strb are combinational from push. No added cycles except one FLUSH beat per misaligned line.
- Valid/ready: `pop_o.valid` never depends on `pop_o.ready`. In FLUSH, valid stays high and data/strb stay stable until the handshake.
- Reset/clear values: state=FIRST, cnt=0, prev_q=0, o_q=0. `flags_o.busy`=0, `line_done`=0, `pop_o.valid`=`push_i.valid`.
- `clear_i` overrides any simultaneous handshake. Clearing mid-line or in FLUSH discards the pending flush beat.
- Back-to-back lines: a FLUSH handshake and the next line's first beat are never in the same cycle. The next line starts the following cycle.
- Line of N words: N+1 output handshakes when o≠0, N when o=0. A new line may be accepted in the cycle after `line_done`.

## Structure
- `hwpe_stream_package` gains `ctrl_sink_realign_t` and `flags_sink_realign_t`.
- Single module. The only instance is `cluster_clock_gating`. The data/strb rotator stays inline; no further sub-module.

## Test plan
All cases use DATA_WIDTH=32.
- o=0, N=3, inputs A,B,C: outputs A,B,C with strb 0xF. `line_done` pulses with C. No extra beat.
- o=1, N=2, inputs 0x44332211 then 0x88776655, outputs in order:
  - 0x33221100 with strb 0xE.
  - 0x77665544 with strb 0xF.
  - 0x00000088 with strb 0x1; `line_done` pulses here.
- o=3, N=1, input 0xDDCCBBAA: outputs 0xAA000000 with strb 0x8, then 0x00DDCCBB with strb 0x7.
- Backpressure: o=2, `pop_o.ready`=0 for 3 cycles during FLUSH. Required: valid held, data/strb stable, `push_i.ready`=0, no input consumed.
- `clear_i` asserted in MID of an o=1 line: next cycle state=FIRST, `busy`=0, no flush beat emitted. The next line starts with strb 0xE.
- `realign`=0 with offset=2: pure passthrough with strb 0xF. `enable`=0 holds FLUSH state across gated cycles.
